seq_loop_monitor: RTL

Synthesizable multi-loop sequencing monitor for HLS-generated FSMs. It samples the design FSM's `cur_state` every cycle and tracks up to `NUM_LOOPS` loops, each described by start, end, quit and post-loop state encodings. For each loop it counts iterations, reports loop exits and flags illegal sequencing: a post-loop state reached without a quit, an unterminated loop at `finish`, or a stalled FSM. It sits beside the DUT in the simulation and emulation harness, and replaces per-loop passive interfaces with active checking.

---
 rtl/seq_loop_pkg.sv | 12 +
 rtl/seq_loop_tracker.sv | 56 +++++
 rtl/seq_loop_monitor.sv | 84 ++++++++
 3 files changed

// File: rtl/seq_loop_pkg.sv
// seq_loop_pkg: shared loop-state enum, default parameters and packed-port slice helper
package seq_loop_pkg;
  typedef enum logic [1:0] {IDLE, RUN, EXITED} loop_state_e;
  localparam int DEF_FSM_WIDTH = 2;
  localparam int DEF_NUM_LOOPS = 4;
  localparam int DEF_NUM_POST = 5;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_STALL_LIMIT = 1024;
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction
endpackage

// File: rtl/seq_loop_tracker.sv
// seq_loop_tracker: one loop's sequencing FSM, iteration counter and sticky error flags
module seq_loop_tracker import seq_loop_pkg::*; #(
  parameter int FSM_WIDTH = DEF_FSM_WIDTH,
  parameter int NUM_POST = DEF_NUM_POST,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          finish,
  input  logic [FSM_WIDTH-1:0]          cur_state,
  input  logic [FSM_WIDTH-1:0]          start_state,
  input  logic [FSM_WIDTH-1:0]          end_state,
  input  logic [FSM_WIDTH-1:0]          quit_state,
  input  logic [NUM_POST*FSM_WIDTH-1:0] post_state,
  input  logic [NUM_POST-1:0]           post_valid,
  output logic                          active,
  output logic                          iter_done,
  output logic                          loop_exit,
  output logic [CNT_WIDTH-1:0]          iter_count,
  output logic                          err_bypass,
  output logic                          err_unterm
);
  loop_state_e state, state_nxt;
  logic run, enter, quit_ev, iter_ev, post_hit;
  always_comb begin
    post_hit = 1'b0;
    for (int j = 0; j < NUM_POST; j++)
      post_hit = post_hit | (post_valid[j] && post_state[slice_lo(j, FSM_WIDTH) +: FSM_WIDTH] == cur_state);
    run = state == RUN;
    enter = en && !finish && !run && cur_state == start_state;
    quit_ev = en && run && cur_state == quit_state;
    // a one-state loop counts its entry cycle as an iteration too
    iter_ev = en && cur_state == end_state && (enter || (run && !quit_ev));
    state_nxt = (!en || finish) ? IDLE : quit_ev ? EXITED : enter ? RUN : state;
  end
  assign active = run;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      iter_done <= 1'b0;
      loop_exit <= 1'b0;
      iter_count <= '0;
      err_bypass <= 1'b0;
      err_unterm <= 1'b0;
    end else begin
      iter_done <= iter_ev;
      loop_exit <= quit_ev;
      iter_count <= enter ? CNT_WIDTH'(iter_ev) :
                    (iter_ev && ~&iter_count) ? iter_count + CNT_WIDTH'(1) : iter_count;
      err_bypass <= err_bypass | (en && run && !quit_ev && post_hit);
      err_unterm <= err_unterm | (finish && run && !quit_ev);
    end
endmodule

// File: rtl/seq_loop_monitor.sv
// seq_loop_monitor: multi-loop HLS FSM sequencing monitor; SEQ_LOOP_STALL_CHECK_EN builds the stall detector
module seq_loop_monitor import seq_loop_pkg::*; #(
  parameter int FSM_WIDTH = DEF_FSM_WIDTH,
  parameter int NUM_LOOPS = DEF_NUM_LOOPS,
  parameter int NUM_POST = DEF_NUM_POST,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [FSM_WIDTH-1:0]                    cur_state,
  input  logic                                    finish,
  input  logic [NUM_LOOPS*FSM_WIDTH-1:0]          iter_start_state,
  input  logic [NUM_LOOPS*FSM_WIDTH-1:0]          iter_end_state,
  input  logic [NUM_LOOPS*FSM_WIDTH-1:0]          quit_state,
  input  logic [NUM_LOOPS*NUM_POST*FSM_WIDTH-1:0] post_state,
  input  logic [NUM_LOOPS*NUM_POST-1:0]           post_valid,
  input  logic [NUM_LOOPS-1:0]                    loop_en,
  output logic [NUM_LOOPS-1:0]                    loop_active,
  output logic [NUM_LOOPS-1:0]                    iter_done,
  output logic [NUM_LOOPS-1:0]                    loop_exit,
  output logic [NUM_LOOPS*CNT_WIDTH-1:0]          iter_count,
  output logic [NUM_LOOPS-1:0]                    err_bypass,
  output logic [NUM_LOOPS-1:0]                    err_unterm,
  output logic                                    stall,
  output logic                                    done
);
  for (genvar i = 0; i < NUM_LOOPS; i++) begin : g_loop
    seq_loop_tracker #(
      .FSM_WIDTH(FSM_WIDTH),
      .NUM_POST(NUM_POST),
      .CNT_WIDTH(CNT_WIDTH)
    ) u_trk (
      .clock(clock),
      .reset(reset),
      .en(loop_en[i]),
      .finish(finish),
      .cur_state(cur_state),
      .start_state(iter_start_state[slice_lo(i, FSM_WIDTH) +: FSM_WIDTH]),
      .end_state(iter_end_state[slice_lo(i, FSM_WIDTH) +: FSM_WIDTH]),
      .quit_state(quit_state[slice_lo(i, FSM_WIDTH) +: FSM_WIDTH]),
      .post_state(post_state[slice_lo(i, NUM_POST * FSM_WIDTH) +: NUM_POST * FSM_WIDTH]),
      .post_valid(post_valid[slice_lo(i, NUM_POST) +: NUM_POST]),
      .active(loop_active[i]),
      .iter_done(iter_done[i]),
      .loop_exit(loop_exit[i]),
      .iter_count(iter_count[slice_lo(i, CNT_WIDTH) +: CNT_WIDTH]),
      .err_bypass(err_bypass[i]),
      .err_unterm(err_unterm[i])
    );
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) done <= 1'b0;
    else done <= finish;
`ifdef SEQ_LOOP_STALL_CHECK_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  logic [FSM_WIDTH-1:0] prev_state;
  logic [SW-1:0] run_len, run_nxt;
  logic hold_ok, counting;
  always_comb begin
    hold_ok = 1'b0;
    // a one-state loop legitimately parks in its body state
    for (int k = 0; k < NUM_LOOPS; k++)
      hold_ok = hold_ok | (loop_active[k] &&
        iter_start_state[slice_lo(k, FSM_WIDTH) +: FSM_WIDTH] == iter_end_state[slice_lo(k, FSM_WIDTH) +: FSM_WIDTH] &&
        cur_state == iter_start_state[slice_lo(k, FSM_WIDTH) +: FSM_WIDTH]);
    counting = |loop_active && !hold_ok;
    run_nxt = !counting ? '0 : cur_state != prev_state ? SW'(1) :
              run_len == SW'(STALL_LIMIT) ? run_len : run_len + SW'(1);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      prev_state <= '0;
      run_len <= '0;
      stall <= 1'b0;
    end else begin
      prev_state <= cur_state;
      run_len <= run_nxt;
      stall <= stall | (run_nxt == SW'(STALL_LIMIT));
    end
`else
  assign stall = 1'b0;
`endif
endmodule
